// File: rtl/pwm_voice_pkg.sv
// pwm_voice_pkg: shared widths, slew state encoding and arithmetic helpers
// for the PWM voice.
//   ENV_W        - amplitude width (9 bits)
//   TOP_W        - PWM counter / top width (8 bits)
//   slew_state_t - SILENT / ATTACK / DECAY / SUSTAIN
//   step_toward  - move a level one step toward a target
//   classify     - slew state from the level and its target
//   scale_cmp    - (level * (top+1)) >> 9 using an 18-bit product
package pwm_voice_pkg;

  localparam int ENV_W = 9;
  localparam int TOP_W = 8;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ATTACK  = 2'd1,
    DECAY   = 2'd2,
    SUSTAIN = 2'd3
  } slew_state_t;

  function automatic logic [ENV_W-1:0] step_toward(input logic [ENV_W-1:0] level,
                                                   input logic [ENV_W-1:0] target);
    logic [ENV_W-1:0] res;
    if (level < target) begin
      res = level + ENV_W'(1);
    end else if (level > target) begin
      res = level - ENV_W'(1);
    end else begin
      res = level;
    end
    return res;
  endfunction

  function automatic slew_state_t classify(input logic [ENV_W-1:0] level,
                                           input logic [ENV_W-1:0] target);
    slew_state_t st;
    if ((level == ENV_W'(0)) && (target == ENV_W'(0))) begin
      st = SILENT;
    end else if (level < target) begin
      st = ATTACK;
    end else if (level > target) begin
      st = DECAY;
    end else begin
      st = SUSTAIN;
    end
    return st;
  endfunction

  // The product is at most 511*256, so the upper ENV_W bits never exceed top+1.
  function automatic logic [ENV_W-1:0] scale_cmp(input logic [ENV_W-1:0] level,
                                                 input logic [TOP_W:0]   top_plus1);
    logic [ENV_W+TOP_W:0] prod;
    prod = {{(TOP_W+1){1'b0}}, level} * {{ENV_W{1'b0}}, top_plus1};
    return prod[ENV_W+TOP_W -: ENV_W];
  endfunction

endpackage

// File: rtl/pwm_envelope_slew.sv
// pwm_envelope_slew: once-per-period amplitude slew and its state machine.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   wrap        - high in the cycle the PWM counter wraps; only then do
//                 level and state move
//   target      - requested amplitude, sampled in the wrap cycle
//   level       - current slewed amplitude (registered)
//   level_next  - amplitude that will be loaded at this edge (combinational)
//   state       - slew state (registered)
module pwm_envelope_slew
  import pwm_voice_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrap,
  input  logic [ENV_W-1:0] target,
  output logic [ENV_W-1:0] level,
  output logic [ENV_W-1:0] level_next,
  output slew_state_t      state
);

  slew_state_t state_next;

  // Next level and state; the state is classified from the post-step level.
  always_comb begin
    level_next = level;
    state_next = state;
    if (wrap) begin
      level_next = step_toward(level, target);
      state_next = classify(step_toward(level, target), target);
    end else begin
      level_next = level;
      state_next = state;
    end
  end

  // Level and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= ENV_W'(0);
      state <= SILENT;
    end else begin
      level <= level_next;
      state <= state_next;
    end
  end

endmodule

// File: rtl/pwm_voice.sv
// pwm_voice: single PWM audio voice. A phase accumulator produces a square
// wave whose polarity gates a slewed amplitude into a PWM compare value.
// Ports:
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_top            - requested PWM top; period is i_top+1 clocks
//   i_top_valid      - i_top qualifier (may stay high)
//   i_phase_delta    - per-clock phase increment
//   i_envelope       - target amplitude
//   o_pwm            - registered PWM bit
//   o_period_start   - high while the PWM counter is 0
//   o_level          - current slewed amplitude
//   o_state          - slew state
module pwm_voice
  import pwm_voice_pkg::*;
#(
  parameter int               ACC_W     = 32,
  parameter logic [TOP_W-1:0] TOP_RESET = 8'hff
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [TOP_W-1:0] i_top,
  input  logic             i_top_valid,
  input  logic [ACC_W-1:0] i_phase_delta,
  input  logic [ENV_W-1:0] i_envelope,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic [ENV_W-1:0] o_level,
  output logic [1:0]       o_state
);

  logic [ACC_W-1:0] acc;
  logic [TOP_W-1:0] cnt;
  logic [TOP_W-1:0] cnt_next;
  logic [TOP_W-1:0] top_cur;
  logic [TOP_W-1:0] top_pend;
  logic [TOP_W-1:0] top_next;
  logic [TOP_W-1:0] pend_next;
  logic [TOP_W:0]   top_plus1;
  logic [ENV_W-1:0] cmp;
  logic [ENV_W-1:0] cmp_next;
  logic [ENV_W-1:0] level;
  logic [ENV_W-1:0] level_next;
  logic             wrap;
  logic             sq;
  slew_state_t      state;

  pwm_envelope_slew u_slew (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .wrap       (wrap),
    .target     (i_envelope),
    .level      (level),
    .level_next (level_next),
    .state      (state)
  );

  assign sq             = acc[ACC_W-1];
  assign o_period_start = (cnt == TOP_W'(0));
  assign o_level        = level;
  assign o_state        = state;

  // Wrap detection, top handshake and compare value. A top presented in the
  // wrap cycle itself bypasses the pending register so it is not lost.
  always_comb begin
    wrap      = (cnt == top_cur);
    top_next  = top_cur;
    pend_next = top_pend;
    cnt_next  = cnt + TOP_W'(1);
    cmp_next  = cmp;
    if (i_top_valid) begin
      pend_next = i_top;
    end else begin
      pend_next = top_pend;
    end
    if (wrap) begin
      if (i_top_valid) begin
        top_next = i_top;
      end else begin
        top_next = top_pend;
      end
      cnt_next = TOP_W'(0);
    end else begin
      top_next = top_cur;
      cnt_next = cnt + TOP_W'(1);
    end
    top_plus1 = {1'b0, top_next} + (TOP_W+1)'(1);
    if (wrap) begin
      if (sq) begin
        cmp_next = scale_cmp(level_next, top_plus1);
      end else begin
        cmp_next = ENV_W'(0);
      end
    end else begin
      cmp_next = cmp;
    end
  end

  // Phase accumulator, counter, top registers, compare latch and PWM output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc      <= ACC_W'(0);
      cnt      <= TOP_W'(0);
      top_cur  <= TOP_RESET;
      top_pend <= TOP_RESET;
      cmp      <= ENV_W'(0);
      o_pwm    <= 1'b0;
    end else begin
      acc      <= acc + i_phase_delta;
      cnt      <= cnt_next;
      top_cur  <= top_next;
      top_pend <= pend_next;
      cmp      <= cmp_next;
      o_pwm    <= ({1'b0, cnt} < cmp) && (state != SILENT);
    end
  end

endmodule

// File: tb/tb_pwm_voice.sv
// tb_pwm_voice: scoreboard bench for pwm_voice. A period-level reference
// model pushes one expected record per wrap (level, state, period length,
// number of high PWM clocks); a monitor pops a record at every period start
// and checks the following period against it.
module tb_pwm_voice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  top = 8'd0;
  logic        top_valid = 1'b0;
  logic [31:0] phase_delta = 32'd0;
  logic [8:0]  envelope = 9'd0;
  logic        pwm;
  logic        period_start;
  logic [8:0]  level;
  logic [1:0]  state;

  int total = 0;
  int bad = 0;

  typedef struct {
    int level;
    int st;
    int plen;
    int phigh;
  } rec_t;

  rec_t sb[$];

  // reference model state
  logic [31:0] m_acc = 32'd0;
  int m_pos = 0;
  int m_top = 255;
  int m_pend = 255;
  int m_env = 0;

  pwm_voice dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_top          (top),
    .i_top_valid    (top_valid),
    .i_phase_delta  (phase_delta),
    .i_envelope     (envelope),
    .o_pwm          (pwm),
    .o_period_start (period_start),
    .o_level        (level),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one record per period, from plain arithmetic.
  initial begin
    bit sq;
    int nt, tgt, st, cmpv;
    rec_t r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_acc = 32'd0; m_pos = 0; m_top = 255; m_pend = 255; m_env = 0;
        sb.delete();
      end else begin
        sq = m_acc[31];
        m_acc = m_acc + phase_delta;
        if (m_pos == m_top) begin
          nt  = top_valid ? int'(top) : m_pend;
          tgt = int'(envelope);
          if (m_env < tgt) m_env++;
          else if (m_env > tgt) m_env--;
          if (m_env == 0 && tgt == 0) st = 0;
          else if (m_env < tgt) st = 1;
          else if (m_env > tgt) st = 2;
          else st = 3;
          cmpv = sq ? (m_env * (nt + 1)) / 512 : 0;
          r.level = m_env; r.st = st; r.plen = nt + 1;
          r.phigh = (st != 0) ? cmpv : 0;
          sb.push_back(r);
          m_top = nt;
          m_pos = 0;
        end else begin
          m_pos++;
        end
        if (top_valid) m_pend = int'(top);
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    rec_t cur;
    bit have = 1'b0;
    int len = 0, high = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_pwm", int'(pwm), 0);
        check("reset_start", int'(period_start), 1);
        check("reset_level", int'(level), 0);
        check("reset_state", int'(state), 0);
        cur.level = 0; cur.st = 0; cur.plen = 256; cur.phigh = 0;
        have = 1'b1; len = 0; high = 0;
      end else begin
        if (have) begin
          len++;
          high += int'(pwm);
          if (len > 300) begin
            total++; bad++;
            $display("FAIL period_timeout: got %0d clocks expected %0d", len, cur.plen);
            have = 1'b0;
          end
        end
        if (period_start) begin
          if (have) begin
            check("period_len", len, cur.plen);
            check("pwm_high", high, cur.phigh);
          end
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got period start expected none");
            have = 1'b0;
          end else begin
            cur = sb.pop_front();
            check("level", int'(level), cur.level);
            check("state", int'(state), cur.st);
            have = 1'b1; len = 0; high = 0;
          end
        end
      end
    end
  end

  // Wait (at falling edges) until the current cycle has cnt==p, or the wrap
  // cycle when want_wrap is set.
  task automatic wait_pos(input int p, input bit want_wrap);
    int n = 0;
    while (!(want_wrap ? (m_pos == m_top) : (m_pos == p)) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      total++; bad++;
      $display("FAIL wait_timeout: got no match expected position %0d", p);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset, silent voice for 1000 clocks
    phase_delta = $urandom;
    cycles(3);
    rst_n = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      phase_delta = $urandom;
    end

    // top change requested mid-period at cnt=100
    wait_pos(100, 1'b0);
    top = 8'd3; top_valid = 1'b1;
    @(negedge clk);
    top_valid = 1'b0;
    cycles(300);

    // back to top 255, square toggling every clock, attack to 14
    top = 8'd255; top_valid = 1'b1;
    @(negedge clk);
    top_valid = 1'b0;
    phase_delta = 32'h8000_0000;
    envelope = 9'd14;
    cycles(16 * 256);

    // decay to 2, then to silence
    envelope = 9'd2;
    cycles(14 * 256);
    envelope = 9'd0;
    cycles(4 * 256);

    // top presented in the exact wrap cycle
    envelope = 9'd5;
    phase_delta = $urandom;
    wait_pos(0, 1'b1);
    top = 8'd15; top_valid = 1'b1;
    @(negedge clk);
    top_valid = 1'b0;
    cycles(150);

    // asynchronous reset in the middle of a period
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pwm", int'(pwm), 0);
    check("async_start", int'(period_start), 1);
    check("async_level", int'(level), 0);
    check("async_state", int'(state), 0);
    cycles(2);
    rst_n = 1'b1;

    // randomized traffic with short periods
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      phase_delta = $urandom;
      if ($urandom_range(0, 49) == 0)
        envelope = ($urandom_range(0, 9) == 0) ? 9'd511 : 9'($urandom_range(0, 40));
      if ($urandom_range(0, 29) == 0) begin
        top = 8'($urandom_range(0, 31));
        top_valid = 1'b1;
      end else begin
        top_valid = 1'b0;
      end
    end
    top_valid = 1'b0;
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
